// File: rtl/cpu_pkg.sv
// cpu_pkg: types and constants shared by decode, operand fetch and the ALU.
//   op_t      : 3-bit ALU opcode (values 101..111 are legal but non-writing)
//   reg_idx_t : architectural register index
//   word_t    : register / operand word
//   ex_req_t  : contents of the execute-stage pipeline register
//   op_writes : 1 when the opcode produces a register result
package cpu_pkg;

   localparam int DATA_W = 8;
   localparam int NREG   = 8;
   localparam int IDX_W  = $clog2(NREG);

   typedef enum logic [2:0] {
      OP_AND = 3'b000,
      OP_XOR = 3'b001,
      OP_SHL = 3'b010,
      OP_SHR = 3'b011,
      OP_ADD = 3'b100
   } op_t;

   typedef logic [IDX_W-1:0]  reg_idx_t;
   typedef logic [DATA_W-1:0] word_t;

   typedef struct packed {
      op_t      op;
      word_t    r1;
      word_t    r2;
      reg_idx_t rd;
      logic     rd_we;
   } ex_req_t;

   // Opcodes 000..100 write RD; the upper encodings only flow through.
   function automatic logic op_writes(op_t op);
      logic [2:0] v;
      v = op;
      return (v <= 3'd4);
   endfunction

endpackage

// File: rtl/reg_file.sv
// reg_file: NREG x DATA_W architectural register file.
//   clk_i, rst_i         : clock, synchronous active-high reset (clears all)
//   ra_addr_i/ra_data_o  : combinational read port A
//   rb_addr_i/rb_data_o  : combinational read port B
//   we_i/waddr_i/wdata_i : synchronous write port
// Reads return the stored value only; writeback bypass is done by the caller.
module reg_file
   import cpu_pkg::*;
(
   input  logic     clk_i,
   input  logic     rst_i,
   input  reg_idx_t ra_addr_i,
   output word_t    ra_data_o,
   input  reg_idx_t rb_addr_i,
   output word_t    rb_data_o,
   input  logic     we_i,
   input  reg_idx_t waddr_i,
   input  word_t    wdata_i
);

   word_t [NREG-1:0] mem_q;

   assign ra_data_o = mem_q[ra_addr_i];
   assign rb_data_o = mem_q[rb_addr_i];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mem_q <= '0;
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: operand read / issue stage feeding the ALU.
//   CLK, RESET                 : clock, synchronous active-high reset
//   IN_VALID/IN_READY          : decoded instruction handshake
//   IN_OP, IN_RA, IN_RB        : opcode, src1/dest index, src2 index
//   OUT_VALID/OUT_READY        : execute register handshake
//   OP, R1, R2, RD, RD_WE      : execute register contents (drive the ALU)
//   WB_EN, WB_ADDR, WB_DATA    : register file writeback
// A busy bit per register tracks outstanding writes; a source that is busy
// and not being written back this very cycle stalls the input.
module operand_fetch
   import cpu_pkg::*;
(
   input  logic              CLK,
   input  logic              RESET,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [2:0]        IN_OP,
   input  logic [IDX_W-1:0]  IN_RA,
   input  logic [IDX_W-1:0]  IN_RB,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic [2:0]        OP,
   output logic [DATA_W-1:0] R1,
   output logic [DATA_W-1:0] R2,
   output logic [IDX_W-1:0]  RD,
   output logic              RD_WE,
   input  logic              WB_EN,
   input  logic [IDX_W-1:0]  WB_ADDR,
   input  logic [DATA_W-1:0] WB_DATA
);

   op_t             in_op;
   word_t           ra_raw, rb_raw;
   word_t           opa, opb;
   logic            wb_hit_a, wb_hit_b;
   logic            hazard;
   logic            accept;

   ex_req_t         ex_q, ex_d;
   logic            out_valid_q, out_valid_d;
   logic [NREG-1:0] busy_q, busy_d;

   assign in_op = op_t'(IN_OP);

   reg_file u_rf (
      .clk_i     (CLK),
      .rst_i     (RESET),
      .ra_addr_i (IN_RA),
      .ra_data_o (ra_raw),
      .rb_addr_i (IN_RB),
      .rb_data_o (rb_raw),
      .we_i      (WB_EN),
      .waddr_i   (WB_ADDR),
      .wdata_i   (WB_DATA)
   );

   // Same-cycle writeback is forwarded and also resolves the hazard on it.
   assign wb_hit_a = WB_EN && (WB_ADDR == IN_RA);
   assign wb_hit_b = WB_EN && (WB_ADDR == IN_RB);
   assign opa      = wb_hit_a ? WB_DATA : ra_raw;
   assign opb      = wb_hit_b ? WB_DATA : rb_raw;

   // IN_RA doubles as destination, so its check also covers write-after-write.
   assign hazard   = (busy_q[IN_RA] && !wb_hit_a) || (busy_q[IN_RB] && !wb_hit_b);
   assign IN_READY = !hazard && (!out_valid_q || OUT_READY);
   assign accept   = IN_VALID && IN_READY;

   always_comb begin
      ex_d        = ex_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;

      if (accept) begin
         ex_d.op     = in_op;
         ex_d.r1     = opa;
         ex_d.r2     = opb;
         ex_d.rd     = IN_RA;
         ex_d.rd_we  = op_writes(in_op);
         out_valid_d = 1'b1;
      end else if (OUT_READY) begin
         out_valid_d = 1'b0;
      end

      // Clear first so a new owner of the same register keeps it busy.
      if (WB_EN) begin
         busy_d[WB_ADDR] = 1'b0;
      end
      if (accept && op_writes(in_op)) begin
         busy_d[IN_RA] = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         ex_q        <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= '0;
      end else begin
         ex_q        <= ex_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign OUT_VALID = out_valid_q;
   assign OP        = ex_q.op;
   assign R1        = ex_q.r1;
   assign R2        = ex_q.r2;
   assign RD        = ex_q.rd;
   assign RD_WE     = ex_q.rd_we;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: a driver issues directed and random traffic and
// pushes the expected execute-register contents into a queue using an
// abstract register/busy model; a monitor on the falling edge compares
// whatever the DUT presents against the head of that queue.
module tb_operand_fetch;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       IN_VALID;
   logic       IN_READY;
   logic [2:0] IN_OP, IN_RA, IN_RB;
   logic       OUT_VALID;
   logic       OUT_READY;
   logic [2:0] OP;
   logic [7:0] R1, R2;
   logic [2:0] RD;
   logic       RD_WE;
   logic       WB_EN;
   logic [2:0] WB_ADDR;
   logic [7:0] WB_DATA;

   operand_fetch dut (
      .CLK(CLK), .RESET(RESET),
      .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .IN_OP(IN_OP), .IN_RA(IN_RA), .IN_RB(IN_RB),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
      .OP(OP), .R1(R1), .R2(R2), .RD(RD), .RD_WE(RD_WE),
      .WB_EN(WB_EN), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [2:0] op;
      logic [7:0] r1;
      logic [7:0] r2;
      logic [2:0] rd;
      logic       we;
   } exp_t;

   exp_t       q[$];
   logic [7:0] m_regs[8];
   bit         m_busy[8];
   bit         m_ov;
   int         checks = 0;
   int         errors = 0;

   // Monitor: every presented instruction must match the oldest expected one.
   always @(negedge CLK) begin
      if (!RESET) begin
         checks++;
         if (OUT_VALID !== m_ov) begin
            errors++;
            $display("FAIL out_valid: got %b expected %b at %0t", OUT_VALID, m_ov, $time);
         end
         if (OUT_VALID === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL out_unexpected: got op=%0d rd=%0d but expected nothing at %0t", OP, RD, $time);
            end else begin
               if ({OP, R1, R2, RD, RD_WE} !== {q[0].op, q[0].r1, q[0].r2, q[0].rd, q[0].we}) begin
                  errors++;
                  $display("FAIL out_data: got op=%0d r1=%h r2=%h rd=%0d we=%b expected op=%0d r1=%h r2=%h rd=%0d we=%b at %0t",
                           OP, R1, R2, RD, RD_WE, q[0].op, q[0].r1, q[0].r2, q[0].rd, q[0].we, $time);
               end
               if (OUT_READY) void'(q.pop_front());
            end
         end
      end
   end

   // One clock of stimulus; called just after a rising edge, returns just
   // after the following one with the model advanced.
   task automatic cyc(input bit iv, input logic [2:0] op, input logic [2:0] ra,
                      input logic [2:0] rb, input bit ordy, input bit wbe,
                      input logic [2:0] wba, input logic [7:0] wbd);
      bit   haz, rdy, acc, nxt_ov;
      exp_t e;
      IN_VALID = iv; IN_OP = op; IN_RA = ra; IN_RB = rb;
      OUT_READY = ordy; WB_EN = wbe; WB_ADDR = wba; WB_DATA = wbd;
      #2;
      haz = (m_busy[ra] && !(wbe && wba == ra)) || (m_busy[rb] && !(wbe && wba == rb));
      rdy = !haz && (!m_ov || ordy);
      checks++;
      if (IN_READY !== rdy) begin
         errors++;
         $display("FAIL in_ready: got %b expected %b (op=%0d ra=%0d rb=%0d) at %0t", IN_READY, rdy, op, ra, rb, $time);
      end
      acc = iv && rdy;
      if (acc) begin
         e.op = op;
         e.r1 = (wbe && wba == ra) ? wbd : m_regs[ra];
         e.r2 = (wbe && wba == rb) ? wbd : m_regs[rb];
         e.rd = ra;
         e.we = (op <= 3'd4);
         q.push_back(e);
      end
      nxt_ov = acc ? 1'b1 : ((m_ov && ordy) ? 1'b0 : m_ov);
      if (wbe) begin
         m_regs[wba] = wbd;
         m_busy[wba] = 1'b0;
      end
      if (acc && op <= 3'd4) m_busy[ra] = 1'b1;
      @(posedge CLK);
      #1;
      m_ov = nxt_ov;
   endtask

   task automatic do_reset();
      RESET = 1'b1; IN_VALID = 1'b1; IN_OP = 3'd4; IN_RA = 3'd3; IN_RB = 3'd3;
      OUT_READY = 1'b0; WB_EN = 1'b1; WB_ADDR = 3'd3; WB_DATA = 8'h55;
      repeat (2) @(posedge CLK);
      #1;
      RESET = 1'b0; IN_VALID = 1'b0; WB_EN = 1'b0;
      for (int i = 0; i < 8; i++) begin m_regs[i] = 8'h00; m_busy[i] = 1'b0; end
      m_ov = 1'b0;
      q.delete();
      #1;
      checks++;
      if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got in_ready=%b out_valid=%b expected 1 and 0", IN_READY, OUT_VALID);
      end
   endtask

   task automatic clear_busy();
      for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 1, 1, 3'(i), 8'(i * 17 + 1));
   endtask

   initial begin
      int        wba;
      logic [7:0] rnd;
      RESET = 1'b1; IN_VALID = 0; IN_OP = 0; IN_RA = 0; IN_RB = 0;
      OUT_READY = 0; WB_EN = 0; WB_ADDR = 0; WB_DATA = 0; m_ov = 0;
      @(posedge CLK); #1;
      do_reset();

      // Reset contents: r3 reads 0 even though a write was present in reset.
      cyc(1, 3'd4, 3'd3, 3'd3, 1, 0, 0, 0);
      // Bypass: r1=0x0F written earlier, r2=0xA5 written in the accept cycle.
      cyc(0, 0, 0, 0, 1, 1, 3'd1, 8'h0F);
      cyc(1, 3'd4, 3'd2, 3'd1, 1, 1, 3'd2, 8'hA5);
      // RAW stall on r4, released by its writeback with forwarded 0x3C.
      cyc(1, 3'd1, 3'd4, 3'd5, 1, 0, 0, 0);
      repeat (3) cyc(1, 3'd0, 3'd1, 3'd4, 1, 0, 0, 0);
      cyc(1, 3'd0, 3'd1, 3'd4, 1, 1, 3'd4, 8'h3C);
      clear_busy();
      // Backpressure: SHL held three cycles, next accepted when ready rises.
      cyc(1, 3'd2, 3'd1, 3'd2, 1, 0, 0, 0);
      repeat (3) cyc(1, 3'd4, 3'd3, 3'd0, 0, 0, 0, 0);
      cyc(1, 3'd4, 3'd3, 3'd0, 1, 0, 0, 0);
      clear_busy();
      // Set/clear collision on r6.
      cyc(1, 3'd4, 3'd6, 3'd0, 1, 0, 0, 0);
      cyc(1, 3'd4, 3'd6, 3'd0, 1, 1, 3'd6, 8'h77);
      repeat (2) cyc(1, 3'd0, 3'd0, 3'd6, 1, 0, 0, 0);
      cyc(1, 3'd0, 3'd0, 3'd6, 1, 1, 3'd6, 8'h99);
      clear_busy();
      // Non-writing opcode to r7, dependent issues back-to-back.
      cyc(1, 3'd7, 3'd7, 3'd1, 1, 0, 0, 0);
      cyc(1, 3'd4, 3'd2, 3'd7, 1, 0, 0, 0);
      cyc(1, 3'd6, 3'd7, 3'd7, 1, 0, 0, 0);

      // Random traffic, writebacks biased toward busy registers.
      for (int n = 0; n < 3000; n++) begin
         if (n % 700 == 699) begin
            do_reset();
         end else begin
            wba = $urandom_range(0, 7);
            if ($urandom_range(0, 3) != 0) begin
               for (int k = 0; k < 8; k++) begin
                  if (!m_busy[wba]) wba = (wba + 1) % 8;
               end
            end
            rnd = 8'($urandom);
            cyc($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                3'(wba), rnd);
         end
      end

      // Drain and confirm nothing is left outstanding.
      repeat (4) cyc(0, 0, 0, 0, 1, 0, 0, 0);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending entries expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
